// File: rtl/test_tx_pkg.sv
// rtl/test_tx_pkg.sv - shared state encoding and generator seed for the test-frame transmitter
package test_tx_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DATA = 2'd2,
        S_GAP  = 2'd3
    } tx_state_t;

    localparam logic [15:0] GEN_SEED = 16'h55AA;

endpackage

// File: rtl/test_tx_ctrl.sv
// rtl/test_tx_ctrl.sv - sequences reseeded generator frames onto the MAC TX client port
module test_tx_ctrl
    import test_tx_pkg::*;
#(
    parameter int SIM   = 0,
    parameter int LEN_W = 16,
    parameter int CNT_W = 16,
    parameter int IFG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [LEN_W-1:0] cfg_frame_len,
    input  logic [CNT_W-1:0] cfg_frame_cnt,
    input  logic [IFG_W-1:0] cfg_ifg,
    input  logic [7:0]       gen_data,
    output logic             gen_sof,
    output logic             gen_en,
    input  logic             mac_tx_rdy,
    output logic [7:0]       mac_tx_data,
    output logic             mac_tx_valid,
    output logic             mac_tx_sof,
    output logic             mac_tx_eof,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frames_sent
);

    tx_state_t        state, state_nx;
    logic [LEN_W-1:0] len_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IFG_W-1:0] ifg_q;
    logic [LEN_W-1:0] byte_cnt;
    logic [IFG_W-1:0] gap_cnt;
    logic             stop_pend;
    logic             run_end;
    logic             accept;
    logic             last_frame;
    logic             stop_any;
    logic             unused_ok;

    assign unused_ok = ^{SIM[0], GEN_SEED};

    // Beat outputs come straight from the state register so an async reset drops them at once.
    assign mac_tx_valid = (state == S_DATA);
    assign mac_tx_sof   = mac_tx_valid && (byte_cnt == '0);
    assign mac_tx_eof   = mac_tx_valid && (byte_cnt == len_q - LEN_W'(1));
    assign mac_tx_data  = mac_tx_valid ? gen_data : 8'h00;
    assign accept       = mac_tx_valid && mac_tx_rdy;
    assign gen_en       = accept;
    assign gen_sof      = (state == S_LOAD);
    assign busy         = (state != S_IDLE);

    assign stop_any   = stop_pend || stop;
    assign last_frame = (cnt_q != '0) &&
                        (({1'b0, frames_sent} + (CNT_W+1)'(1)) == {1'b0, cnt_q});

    always_comb begin
        state_nx = state;
        run_end  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = S_LOAD;
            end
            S_LOAD: begin
                if (stop_any) begin
                    state_nx = S_IDLE;
                    run_end  = 1'b1;
                end else begin
                    state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && mac_tx_eof) begin
                    if (stop_any || last_frame) begin
                        state_nx = S_IDLE;
                        run_end  = 1'b1;
                    end else if (ifg_q == '0) begin
                        state_nx = S_LOAD;
                    end else begin
                        state_nx = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (stop_any) begin
                    state_nx = S_IDLE;
                    run_end  = 1'b1;
                end else if (gap_cnt == ifg_q - IFG_W'(1)) begin
                    state_nx = S_LOAD;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= run_end;
        end
    end

    // Config is shadowed at start so mid-run changes wait for the next run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q       <= '0;
            cnt_q       <= '0;
            ifg_q       <= '0;
            frames_sent <= '0;
        end else if (state == S_IDLE && start) begin
            len_q       <= (cfg_frame_len == '0) ? LEN_W'(1) : cfg_frame_len;
            cnt_q       <= cfg_frame_cnt;
            ifg_q       <= cfg_ifg;
            frames_sent <= '0;
        end else if (accept && mac_tx_eof && frames_sent != '1) begin
            frames_sent <= frames_sent + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            if (state == S_LOAD)
                byte_cnt <= '0;
            else if (accept && byte_cnt != '1)
                byte_cnt <= byte_cnt + LEN_W'(1);
            if (state == S_GAP && gap_cnt != '1)
                gap_cnt <= gap_cnt + IFG_W'(1);
            else if (state != S_GAP)
                gap_cnt <= '0;
        end
    end

    // A start+stop collision in IDLE never arms the pending stop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stop_pend <= 1'b0;
        else if (state == S_IDLE || run_end)
            stop_pend <= 1'b0;
        else if (stop)
            stop_pend <= 1'b1;
    end

endmodule

// File: tb/tb_test_tx_ctrl.sv
// tb/tb_test_tx_ctrl.sv - directed self-checking bench for test_tx_ctrl
module tb_test_tx_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] cfg_frame_len = '0;
    logic [15:0] cfg_frame_cnt = '0;
    logic [7:0]  cfg_ifg = '0;
    logic [7:0]  gen_data;
    logic        gen_sof, gen_en;
    logic        mac_tx_rdy = 1'b1;
    logic [7:0]  mac_tx_data;
    logic        mac_tx_valid, mac_tx_sof, mac_tx_eof;
    logic        busy, done;
    logic [15:0] frames_sent;

    int n_chk = 0;
    int n_bad = 0;

    test_tx_ctrl #(.SIM(1), .LEN_W(16), .CNT_W(16), .IFG_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cfg_frame_len(cfg_frame_len), .cfg_frame_cnt(cfg_frame_cnt), .cfg_ifg(cfg_ifg),
        .gen_data(gen_data), .gen_sof(gen_sof), .gen_en(gen_en),
        .mac_tx_rdy(mac_tx_rdy), .mac_tx_data(mac_tx_data), .mac_tx_valid(mac_tx_valid),
        .mac_tx_sof(mac_tx_sof), .mac_tx_eof(mac_tx_eof),
        .busy(busy), .done(done), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
    endfunction

    function automatic logic [7:0] exp_byte(input int k);
        logic [15:0] s;
        s = 16'h55AA;
        for (int j = 0; j < k; j++) s = lfsr_step(s);
        return s[7:0];
    endfunction

    // Behavioural pattern generator standing in for the scrambler.
    logic [15:0] gen_state = 16'h0000;
    assign gen_data = gen_state[7:0];
    always @(posedge clk) begin
        if (gen_sof)     gen_state <= 16'h55AA;
        else if (gen_en) gen_state <= lfsr_step(gen_state);
    end

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    logic [7:0] beat_data[$];
    logic       beat_sof[$];
    logic       beat_eof[$];
    int         beat_cyc[$];
    int         done_cnt = 0;
    int         hold_err = 0;
    logic       prev_stall = 1'b0;
    logic [9:0] prev_beat = '0;

    always @(negedge clk) begin
        if (mac_tx_valid && mac_tx_rdy) begin
            beat_data.push_back(mac_tx_data);
            beat_sof.push_back(mac_tx_sof);
            beat_eof.push_back(mac_tx_eof);
            beat_cyc.push_back(cyc);
        end
        if (done) done_cnt = done_cnt + 1;
        if (prev_stall && (!mac_tx_valid || prev_beat != {mac_tx_data, mac_tx_sof, mac_tx_eof}))
            hold_err = hold_err + 1;
        prev_stall = mac_tx_valid && !mac_tx_rdy;
        prev_beat  = {mac_tx_data, mac_tx_sof, mac_tx_eof};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input int len, input int cnt, input int ifg);
        cfg_frame_len = 16'(len);
        cfg_frame_cnt = 16'(cnt);
        cfg_ifg       = 8'(ifg);
        beat_data.delete(); beat_sof.delete(); beat_eof.delete(); beat_cyc.delete();
        done_cnt = 0;
        hold_err = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max, input bit tog, input int stop_at);
        int  n = 0;
        bit  stopped = 0;
        while (busy && n < max) begin
            @(posedge clk); #1;
            stop = 1'b0;
            if (tog) mac_tx_rdy = ~mac_tx_rdy;
            if (!stopped && stop_at >= 0 && beat_data.size() >= stop_at) begin
                stop    = 1'b1;
                stopped = 1;
            end
            n++;
        end
        stop       = 1'b0;
        mac_tx_rdy = 1'b1;
        chk({tag, ".finished"}, 32'(n < max), 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Expected: frames of len beats, every frame restarting at the seed.
    task automatic check_run(input string tag, input int nbeats, input int len, input int fs);
        chk({tag, ".beats"}, beat_data.size(), nbeats);
        for (int i = 0; i < nbeats && i < beat_data.size(); i++) begin
            chk($sformatf("%s.data%0d", tag, i), beat_data[i], exp_byte(i % len));
            chk($sformatf("%s.sof%0d", tag, i), beat_sof[i], 32'((i % len) == 0));
            chk($sformatf("%s.eof%0d", tag, i), beat_eof[i], 32'((i % len) == len - 1));
        end
        chk({tag, ".frames_sent"}, frames_sent, fs);
        chk({tag, ".done_cnt"}, done_cnt, 1);
        chk({tag, ".busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst.valid", mac_tx_valid, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.frames", frames_sent, 0);
        chk("rst.gen", {gen_sof, gen_en}, 0);
        chk("rst.data", mac_tx_data, 0);
        rst = 1'b1;

        // basic two-frame run with gap
        start_run(4, 2, 3);
        wait_idle("t1", 500, 0, -1);
        check_run("t1", 8, 4, 2);
        if (beat_cyc.size() >= 8) begin
            chk("t1.gap", beat_cyc[4] - beat_cyc[3], 5);
            chk("t1.back2back", beat_cyc[3] - beat_cyc[0], 3);
        end

        // backpressure on alternate cycles
        start_run(4, 2, 3);
        wait_idle("t2", 500, 1, -1);
        check_run("t2", 8, 4, 2);
        chk("t2.hold", hold_err, 0);

        // zero and single-byte frames, no gap
        start_run(0, 3, 0);
        wait_idle("t3a", 500, 0, -1);
        check_run("t3a", 3, 1, 3);
        if (beat_cyc.size() >= 3) chk("t3a.spacing", beat_cyc[2] - beat_cyc[1], 2);
        start_run(1, 3, 0);
        wait_idle("t3b", 500, 0, -1);
        check_run("t3b", 3, 1, 3);

        // continuous run stopped during the 5th frame
        start_run(8, 0, 1);
        wait_idle("t4", 1000, 0, 35);
        check_run("t4", 40, 8, 5);

        // async reset mid-frame, then restart from seed
        start_run(8, 0, 0);
        for (int n = 0; n < 100 && beat_data.size() < 3; n++) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        chk("t5.valid", mac_tx_valid, 0);
        chk("t5.sof_eof", {mac_tx_sof, mac_tx_eof}, 0);
        chk("t5.busy", busy, 0);
        chk("t5.frames", frames_sent, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        start_run(2, 1, 0);
        wait_idle("t5r", 500, 0, -1);
        check_run("t5r", 2, 2, 1);

        // start and cfg change while busy are ignored
        start_run(3, 2, 2);
        repeat (4) @(posedge clk);
        #1;
        cfg_frame_len = 16'd5;
        cfg_frame_cnt = 16'd4;
        cfg_ifg       = 8'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("t6", 500, 0, -1);
        check_run("t6", 6, 3, 2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
